orb_sample_sequencer: RTL and testbench
=======================================

ORB_SAMPLE_SEQUENCER -- requirements
Module: orb_sample_sequencer

Interface
REQ-001 SHALL have parameter NUM_POINTS, default 512, number of sample points in one descriptor pattern (even, 2..512).
REQ-002 SHALL have parameter NUM_ROTATIONS, default 32, number of quantised orientation bins in the rotation LUT (1..64).
REQ-003 SHALL have parameter ROTATE_DELAY, default 2, clock latency of the downstream VectorRotate stage.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to sequence one pattern.
REQ-007 SHALL have port angle  input  6  orientation bin, sampled on accepted start.
REQ-008 SHALL have port ready  input  1  downstream may accept a new point this cycle.
REQ-009 SHALL have ports ix, iy  output  5 each  signed sample coordinates to VectorRotate.
REQ-010 SHALL have ports cos, sin  output  9 each  signed rotation coefficients to VectorRotate.
REQ-011 SHALL have port issue_valid  output  1  ix/iy/cos/sin carry a real point this cycle.
REQ-012 SHALL have ports tag_valid, tag_last  output  1 each  rotated output for a real point / final point.
REQ-013 SHALL have port tag_index  output  9  point index aligned with VectorRotate output.
REQ-014 SHALL have ports busy, done, err  output  1 each  sequence active / one-cycle completion / one-cycle rejected start.

Function
REQ-015 SHALL hold an internal pattern ROM (NUM_POINTS entries of signed 5-bit x,y) and rotation LUT (NUM_ROTATIONS entries of signed 9-bit cos,sin), both combinational reads.
REQ-016 SHALL implement states IDLE, ISSUE, DRAIN, FINISH.
REQ-017 IDLE: start with angle < NUM_ROTATIONS -> latch angle, clear point index to 0, go ISSUE next cycle.
REQ-018 IDLE: start with angle >= NUM_ROTATIONS -> pulse err for one cycle, stay IDLE.
REQ-019 start while not IDLE SHALL be ignored without err.
REQ-020 ISSUE: issue_valid SHALL equal ready; ix/iy SHALL be pattern ROM entry at current index, cos/sin LUT entry at latched angle.
REQ-021 ISSUE: index SHALL advance by 1 only on cycles with issue_valid=1; ready=0 holds index and outputs.
REQ-022 ISSUE: issue at index NUM_POINTS-1 SHALL move to DRAIN next cycle; index SHALL not wrap.
REQ-023 Tag pipeline: tag_valid, tag_index, tag_last SHALL be issue_valid, issued index, (index==NUM_POINTS-1) delayed exactly ROTATE_DELAY cycles, independent of ready.
REQ-024 DRAIN: issue_valid=0; go FINISH in the cycle tag_last is asserted.
REQ-025 FINISH: pulse done for one cycle, return IDLE; a start on the done cycle SHALL be ignored.
REQ-026 busy SHALL be 1 in ISSUE, DRAIN, FINISH; 0 in IDLE.
REQ-027 Outside ISSUE, ix/iy/cos/sin SHALL be driven 0.
REQ-028 tag_valid count per sequence SHALL equal NUM_POINTS exactly, tag_index strictly increasing 0..NUM_POINTS-1.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, index 0, latched angle 0, and all outputs and tag pipeline stages to 0.
REQ-030 Reset mid-sequence SHALL abandon it with no done pulse; in-flight tags SHALL be discarded.
REQ-031 After rst_n rises, first start SHALL be accepted on the first rising edge.

Verification
REQ-032 start, angle=0, ready held 1 -> issue_valid 512 consecutive cycles, first tag_valid 2 cycles after first issue, tag_last at index 511, done 1 cycle after tag_last, busy 515 cycles total.
REQ-033 angle=40, NUM_ROTATIONS=32 -> err one cycle, busy stays 0, no issue_valid.
REQ-034 ready toggled 1,0,1,0 from ISSUE entry -> index advances on alternate cycles, tag_valid pattern equals issue_valid pattern delayed 2, all 512 indices seen once.
REQ-035 With VectorRotate attached, each angle 0..31 -> rotated ox/oy at every tag_valid equal the golden rotated table entry for (angle, tag_index).
REQ-036 rst_n pulsed low at index 100 -> outputs 0 same cycle, no done; new start after release runs full 512 points.
REQ-037 start asserted during ISSUE and on the done cycle -> ignored, no err, single sequence completes.

Source files
------------

// File: rtl/orb_sample_sequencer.sv
// ORB sample sequencer: walks the descriptor pattern for one orientation
// bin, feeds VectorRotate and tracks point tags through its latency.

module orb_sample_sequencer #(
    parameter int NUM_POINTS    = 512,
    parameter int NUM_ROTATIONS = 32,
    parameter int ROTATE_DELAY  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        angle,
    input  logic              ready,
    output logic signed [4:0] ix,
    output logic signed [4:0] iy,
    output logic signed [8:0] cos,
    output logic signed [8:0] sin,
    output logic              issue_valid,
    output logic              tag_valid,
    output logic              tag_last,
    output logic [8:0]        tag_index,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [8:0] LAST_IDX = 9'(NUM_POINTS - 1);

    state_t state_q, state_d;
    logic [8:0] idx_q, idx_d;
    logic [5:0] ang_q, ang_d;

    logic [ROTATE_DELAY-1:0]       tv_q, tv_d;
    logic [ROTATE_DELAY-1:0]       tl_q, tl_d;
    logic [ROTATE_DELAY-1:0][8:0]  ti_q, ti_d;

    logic signed [4:0] rom_x, rom_y;
    logic signed [8:0] lut_c, lut_s;
    logic [5:0]        bin_c, bin_s;

    // First quadrant of 255*cos(pi*k/32), k = 0..16
    function automatic logic [8:0] qcos(input logic [4:0] k);
        case (k)
            5'd0:    qcos = 9'd255;
            5'd1:    qcos = 9'd254;
            5'd2:    qcos = 9'd250;
            5'd3:    qcos = 9'd244;
            5'd4:    qcos = 9'd236;
            5'd5:    qcos = 9'd225;
            5'd6:    qcos = 9'd212;
            5'd7:    qcos = 9'd197;
            5'd8:    qcos = 9'd180;
            5'd9:    qcos = 9'd162;
            5'd10:   qcos = 9'd142;
            5'd11:   qcos = 9'd120;
            5'd12:   qcos = 9'd98;
            5'd13:   qcos = 9'd74;
            5'd14:   qcos = 9'd50;
            5'd15:   qcos = 9'd25;
            default: qcos = 9'd0;
        endcase
    endfunction

    // Full-circle cosine over 64 phase steps, built from quadrant symmetry
    function automatic logic signed [8:0] wave(input logic [5:0] j);
        logic [8:0] m;
        logic       neg;
        if (j <= 6'd16) begin
            m   = qcos(j[4:0]);
            neg = 1'b0;
        end else if (j <= 6'd32) begin
            m   = qcos(5'(6'd32 - j));
            neg = 1'b1;
        end else if (j <= 6'd48) begin
            m   = qcos(5'(j - 6'd32));
            neg = 1'b1;
        end else begin
            m   = qcos(5'(6'd0 - j));
            neg = 1'b0;
        end
        wave = neg ? -$signed(m) : $signed(m);
    endfunction

    // Pattern ROM and rotation LUT, both read combinationally
    always_comb begin
        rom_x = 5'(int'(idx_q) * 5 + 3) ^ 5'b10000;
        rom_y = 5'(int'(idx_q) * 11 + int'(idx_q[8:5])) ^ 5'b10000;
        bin_c = 6'(int'(ang_q) * 64 / NUM_ROTATIONS);
        bin_s = bin_c - 6'd16;
        lut_c = wave(bin_c);
        lut_s = wave(bin_s);
    end

    // Sequencer next-state and outputs
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ang_d       = ang_q;
        issue_valid = 1'b0;
        err         = 1'b0;
        done        = 1'b0;
        busy        = (state_q != IDLE);
        ix          = '0;
        iy          = '0;
        cos         = '0;
        sin         = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (int'(angle) < NUM_ROTATIONS) begin
                        ang_d   = angle;
                        idx_d   = '0;
                        state_d = ISSUE;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            ISSUE: begin
                ix          = rom_x;
                iy          = rom_y;
                cos         = lut_c;
                sin         = lut_s;
                issue_valid = ready;
                if (ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
            end
            DRAIN: begin
                if (tag_last) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag shift chain matching the VectorRotate latency
    always_comb begin
        tv_d    = tv_q;
        tl_d    = tl_q;
        ti_d    = ti_q;
        tv_d[0] = issue_valid;
        tl_d[0] = issue_valid && (idx_q == LAST_IDX);
        ti_d[0] = idx_q;
        for (int k = 1; k < ROTATE_DELAY; k++) begin
            tv_d[k] = tv_q[k-1];
            tl_d[k] = tl_q[k-1];
            ti_d[k] = ti_q[k-1];
        end
    end

    assign tag_valid = tv_q[ROTATE_DELAY-1];
    assign tag_last  = tl_q[ROTATE_DELAY-1];
    assign tag_index = ti_q[ROTATE_DELAY-1];

    // State, index, latched angle and tag chain registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ang_q   <= '0;
            tv_q    <= '0;
            tl_q    <= '0;
            ti_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ang_q   <= ang_d;
            tv_q    <= tv_d;
            tl_q    <= tl_d;
            ti_q    <= ti_d;
        end
    end

endmodule

// File: tb/tb_orb_sample_sequencer.sv
// Randomized scoreboard bench for orb_sample_sequencer: a driver queues
// expected points/tags/events, a monitor pops and compares them.

module tb_orb_sample_sequencer;

    localparam int NP = 512;
    localparam real PI = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [5:0]        angle;
    logic              ready;
    logic signed [4:0] ix, iy;
    logic signed [8:0] cos, sin;
    logic              issue_valid, tag_valid, tag_last;
    logic [8:0]        tag_index;
    logic              busy, done, err;

    orb_sample_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .angle(angle),
        .ready(ready), .ix(ix), .iy(iy), .cos(cos), .sin(sin),
        .issue_valid(issue_valid), .tag_valid(tag_valid),
        .tag_last(tag_last), .tag_index(tag_index),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int c; int s; } iss_t;
    typedef struct { int idx; bit last; } tag_t;

    iss_t iss_q[$];
    tag_t tag_q[$];
    int   done_q[$];
    int   err_q[$];
    int   busy_q[$];

    int total = 0;
    int bad   = 0;

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int px(input int i);
        return ((i * 5 + 3) % 32) - 16;
    endfunction

    function automatic int py(input int i);
        return ((i * 11 + i / 32) % 32) - 16;
    endfunction

    function automatic int ecos(input int a);
        return rnd(255.0 * $cos(2.0 * PI * a / 32.0));
    endfunction

    function automatic int esin(input int a);
        return rnd(255.0 * $sin(2.0 * PI * a / 32.0));
    endfunction

    task automatic flush();
        iss_q.delete();
        tag_q.delete();
        done_q.delete();
        err_q.delete();
        busy_q.delete();
    endtask

    // Called at posedge+1; mode 0 ready=1, 1 alternating, 2 random
    task automatic run_seq(input int a, input int mode, input bit poke,
                           input int abort_at);
        int n;
        int c;
        bit r;
        iss_t e;
        tag_t t;
        for (int i = 0; i < NP; i++) begin
            e.x = px(i);
            e.y = py(i);
            e.c = ecos(a);
            e.s = esin(a);
            iss_q.push_back(e);
            t.idx  = i;
            t.last = (i == NP - 1);
            tag_q.push_back(t);
        end
        start = 1'b1;
        angle = 6'(a);
        ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        c = 0;
        while (n < NP) begin
            if (c == abort_at) begin
                rst_n = 1'b0;
                ready = 1'b0;
                start = 1'b0;
                flush();
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (c % 2 == 0);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            ready = r;
            start = poke && (c == 5);
            angle = poke ? 6'd40 : 6'($urandom);
            n += int'(r);
            c++;
            @(posedge clk); #1;
        end
        ready = 1'b0;
        start = 1'b0;
        done_q.push_back(1);
        busy_q.push_back(c + 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = poke;
        angle = 6'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic bad_start(input int a);
        err_q.push_back(a);
        start = 1'b1;
        angle = 6'(a);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents an output
    initial begin
        bit   h1, h2, pl;
        int   run;
        iss_t e;
        tag_t t;
        h1 = 0; h2 = 0; pl = 0; run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                total++;
                if ({issue_valid, tag_valid, tag_last, busy, done, err,
                     ix, iy, cos, sin, tag_index} != '0) begin
                    bad++;
                    $display("FAIL reset_zero: got iv=%0b tv=%0b busy=%0b ix=%0d cos=%0d want all 0",
                             issue_valid, tag_valid, busy, ix, cos);
                end
                h1 = 0; h2 = 0; pl = 0; run = 0;
            end else begin
                total++;
                if (tag_valid !== h2 || (!tag_valid && tag_last)) begin
                    bad++;
                    $display("FAIL tag_timing: got tv=%0b tl=%0b want tv=%0b",
                             tag_valid, tag_last, h2);
                end
                if (issue_valid) begin
                    total++;
                    if (iss_q.size() == 0) begin
                        bad++;
                        $display("FAIL issue_unexpected: got issue_valid=1 want 0");
                    end else begin
                        e = iss_q.pop_front();
                        if ($signed(ix) != e.x || $signed(iy) != e.y ||
                            $signed(cos) != e.c || $signed(sin) != e.s) begin
                            bad++;
                            $display("FAIL issue_data: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                                     ix, iy, cos, sin, e.x, e.y, e.c, e.s);
                        end
                    end
                end
                if (!busy) begin
                    total++;
                    if ({issue_valid, tag_valid, ix, iy, cos, sin} != '0) begin
                        bad++;
                        $display("FAIL idle_zero: got iv=%0b tv=%0b ix=%0d cos=%0d want 0",
                                 issue_valid, tag_valid, ix, cos);
                    end
                end
                if (tag_valid) begin
                    total++;
                    if (tag_q.size() == 0) begin
                        bad++;
                        $display("FAIL tag_unexpected: got index=%0d want none", tag_index);
                    end else begin
                        t = tag_q.pop_front();
                        if (int'(tag_index) != t.idx || tag_last != t.last) begin
                            bad++;
                            $display("FAIL tag_data: got idx=%0d last=%0b want idx=%0d last=%0b",
                                     tag_index, tag_last, t.idx, t.last);
                        end
                    end
                end
                if (done) begin
                    total++;
                    if (done_q.size() == 0 || !pl) begin
                        bad++;
                        $display("FAIL done: got done=1 prev_last=%0b want expected done after tag_last",
                                 pl);
                    end
                    if (done_q.size() != 0) void'(done_q.pop_front());
                end
                if (err) begin
                    total++;
                    if (err_q.size() == 0) begin
                        bad++;
                        $display("FAIL err_unexpected: got err=1 angle=%0d want 0", angle);
                    end else begin
                        void'(err_q.pop_front());
                    end
                end
                if (busy) begin
                    run++;
                end else if (run > 0) begin
                    total++;
                    if (busy_q.size() == 0) begin
                        bad++;
                        $display("FAIL busy_unexpected: got run=%0d want none", run);
                    end else if (busy_q[0] != run) begin
                        bad++;
                        $display("FAIL busy_len: got %0d want %0d", run, busy_q[0]);
                    end
                    if (busy_q.size() != 0) void'(busy_q.pop_front());
                    run = 0;
                end
                h2 = h1;
                h1 = issue_valid;
                pl = tag_last;
            end
        end
    end

    task automatic check_empty(input string nm, input int sz);
        total++;
        if (sz != 0) begin
            bad++;
            $display("FAIL %s_left: got %0d pending want 0", nm, sz);
        end
    endtask

    // Driver: directed boundaries plus randomized sequences
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        angle = '0;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_seq(0, 0, 1'b0, -1);
        bad_start(40);
        bad_start(32);
        bad_start(63);
        run_seq(int'($urandom_range(1, 30)), 1, 1'b0, -1);
        run_seq(31, 2, 1'b1, -1);
        run_seq(int'($urandom_range(0, 31)), 2, 1'b0, -1);
        run_seq(8, 0, 1'b0, 100);
        run_seq(int'($urandom_range(0, 31)), 0, 1'b0, -1);
        run_seq(int'($urandom_range(0, 31)), 2, 1'b1, -1);
        repeat (5) @(posedge clk);
        #1;
        check_empty("issue", iss_q.size());
        check_empty("tag", tag_q.size());
        check_empty("done", done_q.size());
        check_empty("err", err_q.size());
        check_empty("busy", busy_q.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
